// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, presents it to a combinational imem and
// registers the returned word into IF/ID. Redirects flush IF/ID, stalls freeze everything.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_current,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    logic        advance;
    logic [31:0] pc_next;
    logic [31:0] target_aligned;

    // Redirect overrides stall; only a clean advance consumes the imem word.
    assign advance        = !redirect && !stall;
    assign pc_next        = pc_current + 32'd4;
    assign target_aligned = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_current <= RESET_PC;
        end else if (redirect) begin
            pc_current <= target_aligned;
        end else if (advance) begin
            pc_current <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (advance) begin
            if_id_pc    <= pc_current;
            if_id_instr <= instr;
            if_id_valid <= 1'b1;
        end
    end

    // Low target bits are dropped from the PC; this pulse is the only record of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (|redirect_target[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0000_0000;
        end else if (advance) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a step-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_current;
    logic [31:0] instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_valid, m_mis;

    if_stage dut (
        .clk(clk), .rst(rst), .pc_current(pc_current), .instr(instr),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .misalign(misalign), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0: imem = 32'h0000_0013;
            32'h4: imem = 32'h0010_0093;
            32'h8: imem = 32'h0020_0113;
            32'hC: imem = 32'h0030_8193;
            default: imem = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    always_comb instr = imem(pc_current);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_current,          m_pc);
        chk({tag, ".ipc"},   if_id_pc,            m_ipc);
        chk({tag, ".instr"}, if_id_instr,         m_instr);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
        chk({tag, ".mis"},   {31'h0, misalign},    {31'h0, m_mis});
        chk({tag, ".cnt"},   fetch_count,         m_cnt);
    endtask

    // One clock edge: apply inputs, predict from the rules, sample 1 time unit after the edge.
    task automatic step(input logic s, input logic r, input logic [31:0] t, input string tag);
        stall = s; redirect = r; redirect_target = t;
        if (r) begin
            m_pc = t & 32'hFFFF_FFFC; m_ipc = 0; m_instr = NOP; m_valid = 0; m_mis = (t % 4) != 0;
        end else if (s) begin
            m_mis = 0;
        end else begin
            m_ipc = m_pc; m_instr = imem(m_pc); m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_mis = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: straight-line fetch
        for (int i = 0; i < 4; i++) step(0, 0, 0, "run");
        chk("run.instr4", if_id_instr, 32'h0030_8193);
        chk("run.pc4", if_id_pc, 32'hC);
        chk("run.cnt4", fetch_count, 32'd4);

        // 2: stall after two fetches
        rst = 1'b1; #2; rst = 1'b0; model_reset();
        step(0, 0, 0, "s.a"); step(0, 0, 0, "s.b");
        for (int i = 0; i < 3; i++) step(1, 0, 0, "stall");
        chk("stall.pc", pc_current, 32'h8);
        chk("stall.instr", if_id_instr, 32'h0010_0093);
        chk("stall.cnt", fetch_count, 32'd2);
        step(0, 0, 0, "release");
        chk("release.instr", if_id_instr, 32'h0020_0113);

        // 3: redirect wins over stall
        step(1, 1, 32'h4, "redir_stall");
        chk("rs.pc", pc_current, 32'h4);
        chk("rs.valid", {31'h0, if_id_valid}, 32'h0);
        chk("rs.instr", if_id_instr, NOP);
        step(0, 0, 0, "after_rs");
        chk("ars.instr", if_id_instr, 32'h0010_0093);

        // 4: misaligned target
        step(0, 1, 32'h0000_000A, "mis");
        chk("mis.pc", pc_current, 32'h8);
        chk("mis.pulse", {31'h0, misalign}, 32'h1);
        step(0, 0, 0, "mis_clear");
        chk("mis.clear", {31'h0, misalign}, 32'h0);

        // 5: PC wrap
        step(0, 1, 32'hFFFF_FFFC, "wrap_redir");
        step(0, 0, 0, "wrap1");
        chk("wrap.pc", pc_current, 32'h0);
        chk("wrap.ipc", if_id_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, "wrap2");

        // back-to-back redirects
        step(0, 1, 32'h100, "b2b1");
        step(1, 1, 32'h203, "b2b2");
        step(0, 0, 0, "b2b3");

        // 6: async reset between edges
        #2; rst = 1'b1; #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held");
        #2; rst = 1'b0;
        step(0, 0, 0, "resume1");
        chk("resume.ipc", if_id_pc, 32'h0);
        step(0, 0, 0, "resume2");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        s, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 6) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(s, r, t, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
